// File: rtl/pc_ras.sv
// Program counter with halt/resume FSM, stall, jumps and a return-address stack.
// The RAS is a circular buffer, so overflow drops the oldest entry.
module pc_ras #(
  parameter int unsigned     PC_W      = 10,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter bit              JMP_ABS   = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic                           halt,
  input  logic                           resume,
  input  logic                           branch,
  input  logic                           jump,
  input  logic                           call,
  input  logic                           ret,
  input  logic [PC_W-1:0]                br_off,
  input  logic [PC_W-1:0]                jmp_off,
  output logic [PC_W-1:0]                pc,
  output logic                           halted,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_ovf,
  output logic                           ras_unf
);

  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  typedef enum logic {
    RUN,
    HALTED
  } state_e;

  state_e state_q, state_d;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   tp_q, tp_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            push;
  logic            active;

  logic [PC_W-1:0] mem_q [RAS_DEPTH];

  logic [PC_W-1:0] p1, tgt, btgt;
  logic [PW-1:0]   tp_inc, tp_dec;

  assign p1     = pc_q + PC_W'(1);
  assign tgt    = JMP_ABS ? jmp_off : p1 + jmp_off;
  assign btgt   = p1 + br_off;
  assign tp_inc = (tp_q == LAST) ? '0 : tp_q + PW'(1);
  assign tp_dec = (tp_q == '0) ? LAST : tp_q - PW'(1);
  assign active = (state_q == RUN) && !stall && !halt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:    if (!stall && halt) state_d = HALTED;
      HALTED: if (resume) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    halted    = (state_q == HALTED);
    pc        = pc_q;
    ras_count = cnt_q;
    ras_ovf   = ovf_q;
    ras_unf   = unf_q;
  end

  // First matching control input wins; ret beats call.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    tp_d  = tp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (active) begin
      priority case (1'b1)
        ret && (cnt_q != '0): begin
          pc_d  = mem_q[tp_q];
          tp_d  = tp_dec;
          cnt_d = cnt_q - CW'(1);
        end
        ret: begin
          pc_d  = p1;
          unf_d = 1'b1;
        end
        call: begin
          pc_d = tgt;
          tp_d = tp_inc;
          push = 1'b1;
          if (cnt_q == FULL) ovf_d = 1'b1;
          else cnt_d = cnt_q + CW'(1);
        end
        jump:    pc_d = tgt;
        branch:  pc_d = btgt;
        default: pc_d = p1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      tp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      tp_q  <= tp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[tp_d] <= p1;
  end

endmodule

// File: tb/tb_pc_ras.sv
// Bench for pc_ras: relative- and absolute-jump instances driven in lockstep
// against a queue-based reference model, directed steps then random traffic.
module tb_pc_ras;

  localparam int W = 10;
  localparam int D = 4;
  localparam int M = 1 << W;
  localparam logic [W-1:0] RPC = 10'h010;

  typedef struct packed {
    logic         rst_n;
    logic         stall;
    logic         halt;
    logic         resume;
    logic         branch;
    logic         jump;
    logic         call;
    logic         ret;
    logic [W-1:0] br_off;
    logic [W-1:0] jmp_off;
  } in_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0, halt = 1'b0, resume = 1'b0;
  logic branch = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
  logic [W-1:0] br_off = '0, jmp_off = '0;

  logic [W-1:0] pc_r, pc_a;
  logic         hlt_r, hlt_a, ovf_r, ovf_a, unf_r, unf_a;
  logic [2:0]   cnt_r, cnt_a;

  int tests = 0;
  int fails = 0;

  int m_pc [2];
  bit m_hlt [2];
  bit m_ovf [2];
  bit m_unf [2];
  int m_ras [2][$];

  always #5 clk = ~clk;

  pc_ras #(.PC_W(W), .RAS_DEPTH(D), .RESET_PC(RPC), .JMP_ABS(1'b0)) dut_r (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt), .resume(resume),
    .branch(branch), .jump(jump), .call(call), .ret(ret),
    .br_off(br_off), .jmp_off(jmp_off),
    .pc(pc_r), .halted(hlt_r), .ras_count(cnt_r),
    .ras_ovf(ovf_r), .ras_unf(unf_r)
  );

  pc_ras #(.PC_W(W), .RAS_DEPTH(D), .RESET_PC(RPC), .JMP_ABS(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt), .resume(resume),
    .branch(branch), .jump(jump), .call(call), .ret(ret),
    .br_off(br_off), .jmp_off(jmp_off),
    .pc(pc_a), .halted(hlt_a), .ras_count(cnt_a),
    .ras_ovf(ovf_a), .ras_unf(unf_a)
  );

  function automatic in_t idle();
    in_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic model(input int k, input in_t s, input bit abs);
    int p1, tgt;
    if (!s.rst_n) begin
      m_pc[k] = int'(RPC);
      m_hlt[k] = 0;
      m_ovf[k] = 0;
      m_unf[k] = 0;
      m_ras[k].delete();
    end else if (m_hlt[k]) begin
      if (s.resume) m_hlt[k] = 0;
    end else if (s.stall) begin
    end else if (s.halt) begin
      m_hlt[k] = 1;
    end else begin
      p1 = (m_pc[k] + 1) % M;
      tgt = abs ? int'(s.jmp_off) : (p1 + int'(s.jmp_off)) % M;
      if (s.ret) begin
        if (m_ras[k].size() > 0) m_pc[k] = m_ras[k].pop_back();
        else begin
          m_pc[k] = p1;
          m_unf[k] = 1;
        end
      end else if (s.call) begin
        m_ras[k].push_back(p1);
        if (m_ras[k].size() > D) begin
          void'(m_ras[k].pop_front());
          m_ovf[k] = 1;
        end
        m_pc[k] = tgt;
      end else if (s.jump) m_pc[k] = tgt;
      else if (s.branch) m_pc[k] = (p1 + int'(s.br_off)) % M;
      else m_pc[k] = p1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input in_t s);
    @(negedge clk);
    rst_n = s.rst_n; stall = s.stall; halt = s.halt; resume = s.resume;
    branch = s.branch; jump = s.jump; call = s.call; ret = s.ret;
    br_off = s.br_off; jmp_off = s.jmp_off;
    @(posedge clk);
    model(0, s, 1'b0);
    model(1, s, 1'b1);
    #1;
    chk("pc_rel", 32'(pc_r), 32'(m_pc[0]));
    chk("pc_abs", 32'(pc_a), 32'(m_pc[1]));
    chk("halted_rel", 32'(hlt_r), 32'(m_hlt[0]));
    chk("halted_abs", 32'(hlt_a), 32'(m_hlt[1]));
    chk("count_rel", 32'(cnt_r), 32'(m_ras[0].size()));
    chk("count_abs", 32'(cnt_a), 32'(m_ras[1].size()));
    chk("ovf_rel", 32'(ovf_r), 32'(m_ovf[0]));
    chk("ovf_abs", 32'(ovf_a), 32'(m_ovf[1]));
    chk("unf_rel", 32'(unf_r), 32'(m_unf[0]));
    chk("unf_abs", 32'(unf_a), 32'(m_unf[1]));
  endtask

  // Relative jump that lands the relative-mode instance on target.
  task automatic go_to(input int target);
    in_t s;
    s = idle();
    s.jump = 1'b1;
    s.jmp_off = W'((target - (m_pc[0] + 1)) & (M - 1));
    step(s);
  endtask

  task automatic do_call(input int off);
    in_t s;
    s = idle();
    s.call = 1'b1;
    s.jmp_off = W'(off);
    step(s);
  endtask

  initial begin
    in_t s;

    s = idle(); s.rst_n = 1'b0;
    step(s);
    step(s);
    chk("reset_pc", 32'(pc_r), 32'h010);
    chk("reset_cnt", 32'(cnt_r), 32'd0);
    step(idle());
    chk("run_pc1", 32'(pc_r), 32'h011);
    step(idle());
    chk("run_pc2", 32'(pc_r), 32'h012);

    go_to('h3FE);
    chk("goto_3fe", 32'(pc_r), 32'h3FE);
    s = idle(); s.branch = 1'b1; s.br_off = 10'h002;
    step(s);
    chk("branch_wrap", 32'(pc_r), 32'h001);
    s = idle(); s.jump = 1'b1; s.jmp_off = 10'h3FC;
    step(s);
    chk("jump_neg", 32'(pc_r), 32'h3FE);
    s.jmp_off = 10'h050;
    step(s);
    chk("jump_abs", 32'(pc_a), 32'h050);

    go_to(5);
    do_call(10);
    chk("call1_pc", 32'(pc_r), 32'd16);
    chk("call1_cnt", 32'(cnt_r), 32'd1);
    do_call(4);
    chk("call2_pc", 32'(pc_r), 32'd21);
    chk("call2_cnt", 32'(cnt_r), 32'd2);
    s = idle(); s.ret = 1'b1;
    step(s);
    chk("ret1_pc", 32'(pc_r), 32'd17);
    step(s);
    chk("ret2_pc", 32'(pc_r), 32'd6);
    chk("ret2_cnt", 32'(cnt_r), 32'd0);

    for (int i = 0; i < 5; i++) do_call(int'($urandom_range(0, M - 1)));
    chk("ovf_flag", 32'(ovf_r), 32'd1);
    chk("ovf_cnt", 32'(cnt_r), 32'd4);
    s = idle(); s.ret = 1'b1;
    for (int i = 0; i < 4; i++) step(s);
    step(s);
    chk("unf_flag", 32'(unf_r), 32'd1);
    for (int i = 0; i < 3; i++) step(idle());
    chk("flags_sticky", 32'({ovf_r, unf_r}), 32'd3);

    go_to(7);
    s = idle(); s.halt = 1'b1;
    step(s);
    chk("halt_pc", 32'(pc_r), 32'd7);
    chk("halt_flag", 32'(hlt_r), 32'd1);
    s = idle(); s.jump = 1'b1; s.call = 1'b1; s.jmp_off = 10'h123;
    step(s);
    chk("halt_ignore", 32'(pc_r), 32'd7);
    s = idle(); s.resume = 1'b1; s.halt = 1'b1;
    step(s);
    chk("resume_pc", 32'(pc_r), 32'd7);
    chk("resume_flag", 32'(hlt_r), 32'd0);
    step(idle());
    chk("resume_next", 32'(pc_r), 32'd8);
    s = idle(); s.stall = 1'b1; s.call = 1'b1; s.halt = 1'b1;
    step(s);
    chk("stall_pc", 32'(pc_r), 32'd8);

    s = idle(); s.rst_n = 1'b0;
    step(s);
    do_call(3);
    do_call(9);
    s = idle(); s.call = 1'b1; s.ret = 1'b1;
    step(s);
    chk("call_ret_cnt", 32'(cnt_r), 32'd1);
    do_call(2);
    do_call(2);
    chk("pre_halt_cnt", 32'(cnt_r), 32'd3);
    s = idle(); s.halt = 1'b1;
    step(s);
    s = idle(); s.rst_n = 1'b0; s.resume = 1'b1; s.call = 1'b1;
    step(s);
    chk("rst_halt_pc", 32'(pc_r), 32'h010);
    chk("rst_halt_flag", 32'(hlt_r), 32'd0);
    chk("rst_halt_cnt", 32'(cnt_r), 32'd0);

    for (int i = 0; i < 400; i++) begin
      s.rst_n   = ($urandom_range(0, 60) != 0);
      s.stall   = ($urandom_range(0, 7) == 0);
      s.halt    = ($urandom_range(0, 15) == 0);
      s.resume  = ($urandom_range(0, 2) == 0);
      s.branch  = ($urandom_range(0, 3) == 0);
      s.jump    = ($urandom_range(0, 5) == 0);
      s.call    = ($urandom_range(0, 3) == 0);
      s.ret     = ($urandom_range(0, 3) == 0);
      s.br_off  = W'($urandom);
      s.jmp_off = W'($urandom);
      step(s);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
